// File: rtl/lsu_clkgen_pipe.sv
// ---------------------------------------------------------------------------
// lsu_clkgen_pipe
// Clock-enable and gated-clock generator for a configurable LSU pipe.
//
// Derives per-stage c1 (single pulse), c2 (double pulse), store and
// freeze-aware enables. It also provides a bus clock-ratio strobe and a
// free-running LSU clock enable with an idle hold.
//
// Optional feature macro: RV_LSU_CLKGEN_IDLE_HYST_EN
//   defined   - free_clken is held IDLE_HOLD cycles after the last activity
//   undefined - free_clken is held for one cycle after the last activity
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   scan_mode           forwarded to every clock header
//   clk_override        forces every enable high (freeze still gates)
//   freeze              freezes stages with index < FREEZE_STAGE
//   pipe_valid/store    per-stage packet valid / store flag
//   dma_req/dma_write   DMA access entering stage 0
//   bus_busy            bus or store buffer non-empty
//   bus_ratio           bus clock divide ratio minus 1
//   c1/c2/store_clken   per-stage enables
//   frz_c1/c2_clken     freeze-aware enables for the frozen stages
//   free_clken          free LSU clock enable
//   bus_clk_en          one-cycle bus clock strobe
//   c1_clk, c2_clk, busm_clk, free_clk   gated clocks
// ---------------------------------------------------------------------------
module lsu_clkgen_pipe #(
    parameter int STAGES       = 5,
    parameter int FREEZE_STAGE = 3,
    parameter int IDLE_HOLD    = 4,
    parameter int BUS_RATIO_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_mode,
    input  logic                    clk_override,
    input  logic                    freeze,
    input  logic [STAGES-1:0]       pipe_valid,
    input  logic [STAGES-1:0]       pipe_store,
    input  logic                    dma_req,
    input  logic                    dma_write,
    input  logic                    bus_busy,
    input  logic [BUS_RATIO_W-1:0]  bus_ratio,
    output logic [STAGES-1:0]       c1_clken,
    output logic [STAGES-1:0]       c2_clken,
    output logic [STAGES-1:0]       store_clken,
    output logic [FREEZE_STAGE-1:0] frz_c1_clken,
    output logic [FREEZE_STAGE-1:0] frz_c2_clken,
    output logic                    free_clken,
    output logic                    bus_clk_en,
    output logic [STAGES-1:0]       c1_clk,
    output logic [STAGES-1:0]       c2_clk,
    output logic                    busm_clk,
    output logic                    free_clk
);

    logic [STAGES-1:0]       c1_term_s;   // stage request without the c1_q carry
    logic [STAGES-1:0]       store_term_s;
    logic [STAGES-1:0]       c1_clken_s;
    logic [STAGES-1:0]       c2_clken_s;
    logic [STAGES-1:0]       store_raw_s;
    logic [STAGES-1:0]       store_clken_s;
    logic [FREEZE_STAGE-1:0] frz_c1_s;
    logic [FREEZE_STAGE-1:0] frz_c2_s;
    logic [STAGES-1:0]       c1_q_r;
    logic [FREEZE_STAGE-1:0] frz_q_r;
    logic                    activity_s;
    logic                    hold_active_s;
    logic                    bus_clk_en_s;
    logic [BUS_RATIO_W-1:0]  div_cnt_r;

    // Per-stage enable derivation; all terms are combinational in the inputs.
    always_comb begin
        c1_term_s       = pipe_valid;
        c1_term_s[0]    = pipe_valid[0] | dma_req;
        store_term_s    = pipe_store;
        store_term_s[0] = pipe_store[0] | dma_write;
        c1_clken_s      = c1_term_s | {c1_q_r[STAGES-2:0], 1'b0} | {STAGES{clk_override}};
        c2_clken_s      = c1_clken_s | c1_q_r | {STAGES{clk_override}};
        store_raw_s     = (c1_clken_s & store_term_s) | {STAGES{clk_override}};
        store_clken_s   = store_raw_s;
        for (int i = 0; i < STAGES; i++) begin
            if (i < FREEZE_STAGE) begin
                store_clken_s[i] = store_raw_s[i] & ~freeze;
            end else begin
                store_clken_s[i] = store_raw_s[i];
            end
        end
        // Freeze overrides clk_override on the frozen stages.
        frz_c1_s = (c1_term_s[FREEZE_STAGE-1:0] | {FREEZE_STAGE{clk_override}})
                   & {FREEZE_STAGE{~freeze}};
        frz_c2_s = (frz_c1_s | frz_q_r | {FREEZE_STAGE{clk_override}})
                   & {FREEZE_STAGE{~freeze}};
    end

    // c1 pulse history: one stage per cycle, feeds the next stage and c2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q_r <= {STAGES{1'b0}};
        end else begin
            c1_q_r <= c1_clken_s;
        end
    end

    // Freeze history only advances when its c2 enable fires, so it survives a freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frz_q_r <= {FREEZE_STAGE{1'b0}};
        end else begin
            for (int i = 0; i < FREEZE_STAGE; i++) begin
                if (frz_c2_s[i]) begin
                    frz_q_r[i] <= frz_c1_s[i];
                end else begin
                    frz_q_r[i] <= frz_q_r[i];
                end
            end
        end
    end

    assign activity_s = (|pipe_valid) | dma_req | bus_busy | clk_override;

`ifdef RV_LSU_CLKGEN_IDLE_HYST_EN
    logic [3:0] hold_cnt_r;

    // Idle hysteresis: reload on activity, drain to zero when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= 4'd0;
        end else if (activity_s) begin
            hold_cnt_r <= 4'(IDLE_HOLD);
        end else if (hold_cnt_r != 4'd0) begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign hold_active_s = (hold_cnt_r != 4'd0);
`else
    logic activity_q_r;

    // Single-cycle hold of the free clock after the last activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            activity_q_r <= 1'b0;
        end else begin
            activity_q_r <= activity_s;
        end
    end

    assign hold_active_s = activity_q_r;
`endif

    // A ratio shrunk below the current count fires on the next compare,
    // so a ratio change never stretches a period past 2^BUS_RATIO_W.
    assign bus_clk_en_s = (div_cnt_r >= bus_ratio);

    // Bus ratio divider counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {BUS_RATIO_W{1'b0}};
        end else if (bus_clk_en_s) begin
            div_cnt_r <= {BUS_RATIO_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + BUS_RATIO_W'(1);
        end
    end

    assign c1_clken     = c1_clken_s;
    assign c2_clken     = c2_clken_s;
    assign store_clken  = store_clken_s;
    assign frz_c1_clken = frz_c1_s;
    assign frz_c2_clken = frz_c2_s;
    assign free_clken   = activity_s | hold_active_s;
    assign bus_clk_en   = bus_clk_en_s;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage_hdr
        rvoclkhdr u_c1_hdr (.clk(clk), .en(c1_clken_s[g]), .scan_mode(scan_mode), .l1clk(c1_clk[g]));
        rvoclkhdr u_c2_hdr (.clk(clk), .en(c2_clken_s[g]), .scan_mode(scan_mode), .l1clk(c2_clk[g]));
    end

    rvoclkhdr u_busm_hdr (.clk(clk), .en(bus_clk_en_s), .scan_mode(scan_mode), .l1clk(busm_clk));
    rvoclkhdr u_free_hdr (.clk(clk), .en(free_clken),   .scan_mode(scan_mode), .l1clk(free_clk));

endmodule

// ---------------------------------------------------------------------------
// rvoclkhdr
// Latch-based glitch-free clock gate. The enable is captured while clk is
// low so the gated clock only ever sees whole high phases.
// Ports: clk (in), en (in), scan_mode (in, forces enable), l1clk (out).
// ---------------------------------------------------------------------------
module rvoclkhdr (
    input  logic clk,
    input  logic en,
    input  logic scan_mode,
    output logic l1clk
);

    logic en_latch_r;

    // Transparent-low enable latch.
    always_latch begin
        if (!clk) begin
            en_latch_r <= en | scan_mode;
        end
    end

    assign l1clk = clk & en_latch_r;

endmodule

// File: tb/tb_lsu_clkgen_pipe.sv
// ---------------------------------------------------------------------------
// tb_lsu_clkgen_pipe
// Directed self-checking bench for lsu_clkgen_pipe (STAGES=5, FREEZE_STAGE=3,
// IDLE_HOLD=4). Inputs change 1 ns after a rising edge; outputs are sampled
// 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_lsu_clkgen_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_mode;
    logic       clk_override;
    logic       freeze;
    logic [4:0] pipe_valid;
    logic [4:0] pipe_store;
    logic       dma_req;
    logic       dma_write;
    logic       bus_busy;
    logic [2:0] bus_ratio;
    logic [4:0] c1_clken;
    logic [4:0] c2_clken;
    logic [4:0] store_clken;
    logic [2:0] frz_c1_clken;
    logic [2:0] frz_c2_clken;
    logic       free_clken;
    logic       bus_clk_en;
    logic [4:0] c1_clk;
    logic [4:0] c2_clk;
    logic       busm_clk;
    logic       free_clk;

    int n_checks = 0;
    int n_errors = 0;

    lsu_clkgen_pipe #(.STAGES(5), .FREEZE_STAGE(3), .IDLE_HOLD(4), .BUS_RATIO_W(3)) dut (
        .clk(clk), .rst(rst), .scan_mode(scan_mode), .clk_override(clk_override),
        .freeze(freeze), .pipe_valid(pipe_valid), .pipe_store(pipe_store),
        .dma_req(dma_req), .dma_write(dma_write), .bus_busy(bus_busy),
        .bus_ratio(bus_ratio), .c1_clken(c1_clken), .c2_clken(c2_clken),
        .store_clken(store_clken), .frz_c1_clken(frz_c1_clken),
        .frz_c2_clken(frz_c2_clken), .free_clken(free_clken),
        .bus_clk_en(bus_clk_en), .c1_clk(c1_clk), .c2_clk(c2_clk),
        .busm_clk(busm_clk), .free_clk(free_clk)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        clk_override = 1'b0;
        freeze       = 1'b0;
        pipe_valid   = 5'd0;
        pipe_store   = 5'd0;
        dma_req      = 1'b0;
        dma_write    = 1'b0;
        bus_busy     = 1'b0;
    endtask

    function automatic logic [7:0] load_c1(input int t);
        if (t >= 0 && t < 5) return 8'd1 << t;
        else return 8'd0;
    endfunction

    logic exp_free;

    initial begin
        rst       = 1'b1;
        scan_mode = 1'b0;
        bus_ratio = 3'd0;
        clear_inputs();

        // Reset state with all inputs zero
        #2;
        check_val("rst_c1",     {3'd0, c1_clken},     8'd0);
        check_val("rst_c2",     {3'd0, c2_clken},     8'd0);
        check_val("rst_store",  {3'd0, store_clken},  8'd0);
        check_val("rst_frz_c1", {5'd0, frz_c1_clken}, 8'd0);
        check_val("rst_frz_c2", {5'd0, frz_c2_clken}, 8'd0);
        check_val("rst_free",   {7'd0, free_clken},   8'd0);
        check_val("rst_bus_r0", {7'd0, bus_clk_en},   8'd1);
        bus_ratio = 3'd2;
        #1;
        check_val("rst_bus_r2", {7'd0, bus_clk_en},   8'd0);

        // Bus divider, ratio 2: 0,0,1 repeating from reset release
        next_cycle();
        rst = 1'b0;
        #1;
        check_val("bus_r2", {7'd0, bus_clk_en}, 8'd0);
        for (int i = 1; i < 7; i++) begin
            next_cycle();
            #1;
            check_val("bus_r2", {7'd0, bus_clk_en}, (i % 3 == 2) ? 8'd1 : 8'd0);
        end
        // div_cnt is now 1: switch to ratio 0 mid-count
        next_cycle();
        bus_ratio = 3'd0;
        #1;
        check_val("bus_r0", {7'd0, bus_clk_en}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check_val("bus_r0", {7'd0, bus_clk_en}, 8'd1);
        end

        // Single load propagating through the c1 chain
        for (int i = 0; i < 3; i++) next_cycle();
        for (int t = 0; t < 7; t++) begin
            next_cycle();
            pipe_valid = (t == 0) ? 5'b00001 : 5'b00000;
            #1;
            check_val("load_c1",    {3'd0, c1_clken},    load_c1(t));
            check_val("load_c2",    {3'd0, c2_clken},    load_c1(t) | load_c1(t - 1));
            check_val("load_store", {3'd0, store_clken}, 8'd0);
        end

        // DMA write into stage 0
        next_cycle();
        dma_req   = 1'b1;
        dma_write = 1'b1;
        #1;
        check_val("dma_store", {3'd0, store_clken}, 8'b00001);
        check_val("dma_c1",    {3'd0, c1_clken},    8'b00001);
        next_cycle();
        clear_inputs();
        #1;
        check_val("dma_c1_n1",    {3'd0, c1_clken},    8'b00010);
        check_val("dma_store_n1", {3'd0, store_clken}, 8'd0);

        // Freeze holding a stage-1 store
        for (int i = 0; i < 2; i++) next_cycle();
        next_cycle();
        pipe_valid = 5'b00010;
        pipe_store = 5'b00010;
        #1;
        check_val("pre_frz_c1", {5'd0, frz_c1_clken}, 8'b010);
        check_val("pre_frz_c2", {5'd0, frz_c2_clken}, 8'b010);
        check_val("pre_store",  {3'd0, store_clken},  8'b00010);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            freeze = 1'b1;
            #1;
            check_val("frz_c1",    {5'd0, frz_c1_clken}, 8'd0);
            check_val("frz_c2",    {5'd0, frz_c2_clken}, 8'd0);
            check_val("frz_store", {3'd0, store_clken},  8'd0);
        end
        next_cycle();
        clear_inputs();
        #1;
        check_val("unfrz_c2", {5'd0, frz_c2_clken}, 8'b010);
        check_val("unfrz_c1", {5'd0, frz_c1_clken}, 8'd0);
        next_cycle();
        #1;
        check_val("unfrz_c2_n1", {5'd0, frz_c2_clken}, 8'd0);

        // Freeze wins over clk_override on frozen stages
        next_cycle();
        clk_override = 1'b1;
        freeze       = 1'b1;
        #1;
        check_val("ovr_c1",     {3'd0, c1_clken},     8'b11111);
        check_val("ovr_c2",     {3'd0, c2_clken},     8'b11111);
        check_val("ovr_store",  {3'd0, store_clken},  8'b11000);
        check_val("ovr_frz_c1", {5'd0, frz_c1_clken}, 8'd0);
        check_val("ovr_frz_c2", {5'd0, frz_c2_clken}, 8'd0);
        check_val("ovr_free",   {7'd0, free_clken},   8'd1);
        next_cycle();
        clear_inputs();

        // Free clock hold after bus_busy in cycles 0-1
        for (int i = 0; i < 6; i++) next_cycle();
        for (int t = 0; t < 8; t++) begin
            next_cycle();
            bus_busy = (t < 2);
            #1;
`ifdef RV_LSU_CLKGEN_IDLE_HYST_EN
            exp_free = (t <= 5);
`else
            exp_free = (t <= 2);
`endif
            check_val("hyst_free", {7'd0, free_clken}, {7'd0, exp_free});
        end

        // Reset while c1_q[2] is set
        next_cycle();
        pipe_valid = 5'b00001;
        next_cycle();
        pipe_valid = 5'b00000;
        next_cycle();
        bus_busy = 1'b1;
        next_cycle();
        bus_busy = 1'b0;
        #1;
        check_val("mid_c1",   {3'd0, c1_clken},   8'b01000);
        check_val("mid_c2",   {3'd0, c2_clken},   8'b01100);
        check_val("mid_free", {7'd0, free_clken}, 8'd1);
        rst = 1'b1;
        #1;
        check_val("mrst_c1",   {3'd0, c1_clken},   8'd0);
        check_val("mrst_c2",   {3'd0, c2_clken},   8'd0);
        check_val("mrst_free", {7'd0, free_clken}, 8'd0);
        bus_busy = 1'b1;
        #1;
        check_val("mrst_free_in", {7'd0, free_clken}, 8'd1);
        bus_busy = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        check_val("post_rst_c2", {3'd0, c2_clken}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
